// File: rtl/spi_link_pkg.sv
// Shared definitions for the 16-bit SPI register link: frame geometry and slave command codes.
// Imported by both the master and the register slave.
package spi_link_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned FIELD_W = 12;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] OP_RD_DAT       = 4'b0000;
    localparam logic [OP_W-1:0] OP_RD_DAT_RD    = 4'b0010;
    localparam logic [OP_W-1:0] OP_RD_DAT_RDINC = 4'b0011;
    localparam logic [OP_W-1:0] OP_RD_ADR       = 4'b0100;
    localparam logic [OP_W-1:0] OP_WR_DAT       = 4'b1000;
    localparam logic [OP_W-1:0] OP_WR_DAT_WR    = 4'b1010;
    localparam logic [OP_W-1:0] OP_WR_DAT_WRINC = 4'b1011;
    localparam logic [OP_W-1:0] OP_WR_ADR       = 4'b1100;
    localparam logic [OP_W-1:0] OP_WR_ADR_RD    = 4'b1101;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b; else m = m;
        if (c > m) m = c; else m = m;
        if (d > m) m = d; else m = m;
        return m;
    endfunction

endpackage

// File: rtl/spi_mst_sync2.sv
// Two-flop synchroniser for the asynchronous MISO line, clearing to 0 on reset.
module spi_mst_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture stage followed by one resolution stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_mst_16b.sv
// SPI mode-0 master: serialises one {opcode, field} command MSB-first and returns the
// 12-bit field captured from MISO. SCK is timed from clk, so all pins are registered.
module spi_mst_16b
    import spi_link_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned CS_SETUP = 8,
    parameter int unsigned CS_HOLD  = 8,
    parameter int unsigned CS_IDLE  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OP_W-1:0]    cmd_op,
    input  logic [FIELD_W-1:0] cmd_field,
    output logic               rsp_valid,
    output logic [FIELD_W-1:0] rsp_data,
    output logic               busy,
    output logic               spi_clk,
    output logic               spi_en_n,
    output logic               spi_mosi,
    input  logic               spi_miso
);

    localparam int unsigned TMR_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(32'd1);
    localparam logic [TMR_W-1:0] TMR_DIV   = TMR_W'(CLK_DIV);
    localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(CS_SETUP);
    localparam logic [TMR_W-1:0] TMR_HOLD  = TMR_W'(CS_HOLD);
    localparam logic [TMR_W-1:0] TMR_IDLE  = TMR_W'(CS_IDLE);

    // The slave resynchronises SCK through three flops plus an edge detector.
    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("spi_mst_16b: CLK_DIV must be >= 4");
    end
    if (CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_cs_timing
        $error("spi_mst_16b: CS_SETUP, CS_HOLD and CS_IDLE must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_LO = 3'd2,
        ST_SCK_HI = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } state_e;

    state_e               state_q,     state_d;
    logic [TMR_W-1:0]     tmr_q,       tmr_d;
    logic [4:0]           bitcnt_q,    bitcnt_d;
    logic [FRAME_W-1:0]   shift_q,     shift_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q,      busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [FIELD_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                 sck_q,       sck_d;
    logic                 en_n_q,      en_n_d;
    logic                 mosi_q,      mosi_d;
    logic                 miso_s;

    spi_mst_sync2 u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d_i (spi_miso),
        .q_o (miso_s)
    );

    // Frame sequencing; one shift register carries MOSI out and MISO in.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = ST_SETUP;
                    tmr_d    = TMR_SETUP;
                    bitcnt_d = 5'd16;
                    shift_d  = {cmd_op, cmd_field};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_q == TMR_ONE) begin
                    state_d = ST_SCK_LO;
                    tmr_d   = TMR_DIV;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_SCK_LO: begin
                if (tmr_q == TMR_ONE) begin
                    state_d = ST_SCK_HI;
                    tmr_d   = TMR_DIV;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_SCK_HI: begin
                if (tmr_q == TMR_ONE) begin
                    shift_d  = {shift_q[FRAME_W-2:0], miso_s};
                    bitcnt_d = bitcnt_q - 5'd1;
                    if (bitcnt_d == 5'd0) begin
                        state_d = ST_HOLD;
                        tmr_d   = TMR_HOLD;
                    end else begin
                        state_d = ST_SCK_LO;
                        tmr_d   = TMR_DIV;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_HOLD: begin
                if (tmr_q == TMR_ONE) begin
                    state_d = ST_GAP;
                    tmr_d   = TMR_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_GAP: begin
                if (tmr_q == TMR_ONE) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        // Pins are decoded from the next state so they change on the same edge as the FSM.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        sck_d       = (state_d == ST_SCK_HI);
        en_n_d      = !(state_d inside {ST_SETUP, ST_SCK_LO, ST_SCK_HI, ST_HOLD});
        rsp_valid_d = (state_q == ST_HOLD) && (state_d == ST_GAP);
        rsp_data_d  = rsp_valid_d ? shift_q[FIELD_W-1:0] : rsp_data_q;
        case (state_d)
            ST_SETUP, ST_SCK_LO, ST_SCK_HI: mosi_d = shift_d[FRAME_W-1];
            ST_HOLD:                        mosi_d = mosi_q;
            default:                        mosi_d = 1'b0;
        endcase
    end

    // State and pin registers; reset abandons any frame and releases the bus at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            bitcnt_q    <= 5'd0;
            shift_q     <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            sck_q       <= 1'b0;
            en_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sck_q       <= sck_d;
            en_n_q      <= en_n_d;
            mosi_q      <= mosi_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign spi_clk   = sck_q;
    assign spi_en_n  = en_n_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mst_16b.sv
// Directed bench for spi_mst_16b with a mode-0 slave model that records MOSI and plays MISO.
module tb_spi_mst_16b;
    import spi_link_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_field;
    logic        rsp_valid;
    logic [11:0] rsp_data;
    logic        busy;
    logic        spi_clk;
    logic        spi_en_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] miso_word = 16'h0000;
    logic [15:0] mon_rx    = 16'h0000;
    int          mon_rises = 0;
    logic        prev_en   = 1'b1;
    logic        prev_sck  = 1'b0;
    int          rsp_pulses = 0;
    int          overlap    = 0;

    spi_mst_16b #(
        .CLK_DIV  (4),
        .CS_SETUP (8),
        .CS_HOLD  (8),
        .CS_IDLE  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_field (cmd_field),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .spi_clk   (spi_clk),
        .spi_en_n  (spi_en_n),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    // Slave model: restart on CS fall, sample MOSI on SCK rise, present next MISO bit on SCK fall.
    always @(spi_clk or spi_en_n) begin
        if (spi_en_n) begin
            spi_miso = 1'b0;
        end else if (prev_en) begin
            mon_rises = 0;
            mon_rx    = 16'h0000;
            spi_miso  = miso_word[15];
        end else if (spi_clk && !prev_sck) begin
            mon_rx    = {mon_rx[14:0], spi_mosi};
            mon_rises = mon_rises + 1;
        end else if (!spi_clk && prev_sck && mon_rises < 16) begin
            spi_miso = miso_word[15 - mon_rises];
        end
        prev_en  = spi_en_n;
        prev_sck = spi_clk;
    end

    // Count response cycles and any cycle where ready and response coincide.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_pulses = rsp_pulses + 1;
        if (cmd_ready === 1'b1 && rsp_valid === 1'b1) overlap = overlap + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in a cycle where cmd_valid & cmd_ready hold; iteration i observes cycle T+i.
    task automatic run_frame(input bit keep_valid, input bit scramble,
                             output int low_cnt, output int rsp_at,
                             output int ready_at, output int high_cnt);
        low_cnt  = 0;
        rsp_at   = 0;
        ready_at = 0;
        high_cnt = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (i == 1 && !keep_valid) cmd_valid = 1'b0;
            if (i == 40 && scramble) begin
                cmd_op    = 4'b0110;
                cmd_field = 12'hF0F;
            end
            if (spi_en_n === 1'b0) low_cnt++;
            else if (low_cnt > 0) high_cnt++;
            if (rsp_valid === 1'b1 && rsp_at == 0) rsp_at = i;
            if (cmd_ready === 1'b1) begin
                ready_at = i;
                break;
            end
        end
    endtask

    int low_c, rsp_c, rdy_c, high_c, p0;

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'b0000;
        cmd_field = 12'h000;

        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("reset_pins", {31'd0, spi_en_n} << 2 | {31'd0, spi_clk} << 1 | {31'd0, cmd_ready},
                32'h4);
        end
        chk("reset_rsp", {19'd0, busy, rsp_valid, rsp_data}, 32'h0);
        chk("reset_mosi", {31'd0, spi_mosi}, 32'h0);
        rst = 1'b0;
        chk("ready_low_at_release", {31'd0, cmd_ready}, 32'h0);
        @(posedge clk); #1;
        chk("ready_after_release", {31'd0, cmd_ready}, 32'h1);

        // Write frame: 1010 / 0x0A5, MISO plays 0x5A5A.
        miso_word = 16'h5A5A;
        cmd_op    = OP_WR_DAT_WR;
        cmd_field = 12'h0A5;
        cmd_valid = 1'b1;
        p0 = rsp_pulses;
        run_frame(1'b0, 1'b0, low_c, rsp_c, rdy_c, high_c);
        chk("wr_mosi", {16'd0, mon_rx}, 32'hA0A5);
        chk("wr_rises", mon_rises, 32'd16);
        chk("wr_cs_low", low_c, 32'd144);
        chk("wr_rsp_at", rsp_c, 32'd145);
        chk("wr_ready_at", rdy_c, 32'd161);
        chk("wr_rsp_data", {20'd0, rsp_data}, 32'hA5A);
        chk("wr_rsp_pulses", rsp_pulses - p0, 32'd1);

        // Read frame with command inputs scrambled mid-flight.
        miso_word = 16'hF03C;
        cmd_op    = OP_RD_DAT_RD;
        cmd_field = 12'h123;
        cmd_valid = 1'b1;
        p0 = rsp_pulses;
        run_frame(1'b0, 1'b1, low_c, rsp_c, rdy_c, high_c);
        chk("rd_mosi", {16'd0, mon_rx}, 32'h2123);
        chk("rd_rsp_data", {20'd0, rsp_data}, 32'h03C);
        chk("rd_rsp_pulses", rsp_pulses - p0, 32'd1);
        chk("rd_cs_low", low_c, 32'd144);
        chk("rd_busy_idle", {31'd0, busy}, 32'h0);

        // Back-to-back: valid stays high across two commands.
        miso_word = 16'h0000;
        cmd_op    = OP_WR_ADR;
        cmd_field = 12'h3C5;
        cmd_valid = 1'b1;
        p0 = rsp_pulses;
        run_frame(1'b1, 1'b0, low_c, rsp_c, rdy_c, high_c);
        cmd_op    = OP_WR_DAT;
        cmd_field = 12'h05A;
        chk("b2b_first_mosi", {16'd0, mon_rx}, 32'hC3C5);
        chk("b2b_ready_gap", rdy_c - rsp_c, 32'd16);
        chk("b2b_cs_high", high_c, 32'd17);
        miso_word = 16'h0ABC;
        run_frame(1'b0, 1'b0, low_c, rsp_c, rdy_c, high_c);
        chk("b2b_second_mosi", {16'd0, mon_rx}, 32'h805A);
        chk("b2b_second_low", low_c, 32'd144);
        chk("b2b_second_rsp", {20'd0, rsp_data}, 32'hABC);
        chk("b2b_pulses", rsp_pulses - p0, 32'd2);

        // Reset after the 7th SCK rise.
        miso_word = 16'hFFFF;
        cmd_op    = OP_WR_DAT_WRINC;
        cmd_field = 12'hABC;
        cmd_valid = 1'b1;
        p0 = rsp_pulses;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mon_rises == 7) break;
            @(posedge clk); #1;
        end
        chk("abort_reached_rise7", mon_rises, 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_pins", {30'd0, spi_en_n, spi_clk}, 32'h2);
        chk("abort_busy_ready", {30'd0, busy, cmd_ready}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", {31'd0, cmd_ready}, 32'h1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
        end
        chk("abort_no_rsp", rsp_pulses - p0, 32'd0);
        chk("abort_still_idle", {31'd0, spi_en_n}, 32'h1);

        // Clean frame after the abort.
        miso_word = 16'h0FFF;
        cmd_op    = OP_WR_ADR_RD;
        cmd_field = 12'h00F;
        cmd_valid = 1'b1;
        run_frame(1'b0, 1'b0, low_c, rsp_c, rdy_c, high_c);
        chk("post_abort_mosi", {16'd0, mon_rx}, 32'hD00F);
        chk("post_abort_rises", mon_rises, 32'd16);
        chk("post_abort_rsp", {20'd0, rsp_data}, 32'hFFF);
        chk("post_abort_rsp_at", rsp_c, 32'd145);
        chk("ready_rsp_overlap", overlap, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mst_16b.md
# spi_mst_16b

SPI master that originates the 16-bit command frames consumed by the design's SPI register slave: it takes one {opcode, 12-bit field} command from a local controller, serialises it MSB-first on SCK/CS_N/MOSI (SPI mode 0), captures MISO in the same frame, and returns the captured 12-bit field. It sits directly upstream of the slave, either on a host FPGA driving the board link or in system benches as the reference driver. SCK is derived from the system clock, so no second clock domain is needed.

## Interface
- CLK_DIV, 8, SCK half-period in clk cycles; must be >= 4, elaboration error otherwise; the slave needs a 3-flop sync plus edge detect.
- CS_SETUP, 8, clk cycles from CS_N fall to first SCK rise; must be >= 1.
- CS_HOLD, 8, clk cycles from last SCK fall to CS_N rise; must be >= 1.
- CS_IDLE, 16, minimum clk cycles CS_N stays high between frames; must be >= 1.
- clk  in  1  system clock; the block has one clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  4  frame bits 15-12, the slave command code.
- cmd_field  in  12  frame bits 11-0, address or data.
- rsp_valid  out  1  one-cycle pulse, frame complete.
- rsp_data  out  12  MISO bits captured on SCK rises 5-16; read byte in [7:0].
- busy  out  1  high from accept until the end of the idle gap.
- spi_clk  out  1  SCK, idle low.
- spi_en_n  out  1  chip select, active low.
- spi_mosi  out  1  serial data to slave.
- spi_miso  in  1  serial data from slave; asynchronous, passes through a 2-flop sync.

## Operation
- FSM states: IDLE, SETUP, SCK_LO, SCK_HI, HOLD, GAP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch {cmd_op, cmd_field} into a 16-bit shift register, set bit counter to 16, go to SETUP.
  - cmd_* inputs are ignored while cmd_ready=0.
- SETUP: spi_en_n=0, spi_mosi=frame[15]; CS_SETUP cycles, then SCK_LO.
- SCK_LO: spi_clk=0.
  - For the first bit, MOSI was already presented in SETUP.
  - For later bits, MOSI advances to the next bit on entry, which coincides with the SCK falling edge.
  - Lasts CLK_DIV cycles, then SCK_HI.
- SCK_HI: spi_clk=1 for CLK_DIV cycles.
  - On the last cycle, shift the synced MISO into the capture register and decrement the bit counter.
  - Counter nonzero: go to SCK_LO. Counter zero: go to HOLD with spi_clk=0.
- HOLD: CS_HOLD cycles with spi_clk=0 and spi_en_n=0, then GAP.
- GAP:
  - spi_en_n=1.
  - First GAP cycle: rsp_valid=1 and rsp_data=capture[11:0]; rsp_data holds until the next rsp_valid.
  - After CS_IDLE cycles, go to IDLE.
- Exactly 16 SCK rising edges per frame. No frame is ever truncated except by reset.
- Timing counters are wide enough for max(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) and count down to 1. The bit counter is 5 bits.

## Timing
- Reset values: spi_clk=0, spi_en_n=1, spi_mosi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, FSM=IDLE.
- cmd_ready rises the first cycle after rst deasserts.
- Accept at edge T:
  - spi_en_n low in cycles T+1 through T+CS_SETUP+32*CLK_DIV+CS_HOLD.
  - rsp_valid in cycle T+1+CS_SETUP+32*CLK_DIV+CS_HOLD.
  - cmd_ready returns CS_IDLE cycles after that.
- Back-to-back commands: CS_N high for >= CS_IDLE cycles between frames; cmd_ready and rsp_valid are never high together.
- MISO sample point: 2*CLK_DIV-1 cycles after the SCK fall. This tolerates up to 4 cycles of slave output delay plus the 2-cycle sync at CLK_DIV=4.
- rst mid-frame: the next cycle shows spi_en_n=1 and spi_clk=0. The frame is abandoned with no rsp_valid. The slave resynchronises on the next CS_N fall.

## Structure
- Shared package spi_link_pkg holds:
  - Frame width 16 and field width 12.
  - Opcode constants: RD_DAT 0000, RD_DAT_RD 0010, RD_DAT_RDINC 0011, RD_ADR 0100, WR_DAT 1000, WR_DAT_WR 1010, WR_DAT_WRINC 1011, WR_ADR 1100, WR_ADR_RD 1101.
- The slave will import the same package.
- One sub-module, spi_mst_sync2, is the 2-flop MISO synchroniser with reset value 0. Everything else stays in one module.

## Test plan
- Reset: rst high 3 cycles -> spi_en_n=1, spi_clk=0, cmd_ready=0 throughout; cmd_ready=1 in the first cycle after release.
- Write (CLK_DIV=4, CS_SETUP=CS_HOLD=8, CS_IDLE=16): op 1010, field 0x0A5 -> MOSI sampled at the 16 SCK rises equals 1010_0000_1010_0101; spi_en_n low for exactly 144 cycles; rsp_valid at T+145.
- Read capture: slave model drives 0x03C on MISO bits for rises 5-16 -> rsp_data=0x03C with a single-cycle rsp_valid.
- Back-to-back: cmd_valid held with two commands -> second accepted exactly 16 cycles after the first rsp_valid; spi_en_n high >= 16 cycles between frames.
- Reset after the 7th SCK rise -> next cycle spi_en_n=1 and spi_clk=0; no rsp_valid; the following command produces a clean 16-rise frame.
- cmd_op/cmd_field changed while busy -> the frame in flight is unaffected and the new values are not latched until cmd_ready=1.
